// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO management master: frame layout, opcodes,
// frame lengths, controller state encoding and the debug view of the FSM.
package mdio_pkg;

   // Frame lengths, in MDC periods
   localparam int FRAME_BITS      = 32;
   localparam int READ_DRIVE_BITS = 14;
   localparam int TA_BITS         = 2;
   localparam int DATA_BITS       = 16;
   localparam int BIT_IDX_W       = 6;

   // Field codes
   localparam logic [1:0] ST_CODE  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   // Field bit positions inside the 32-bit frame (MSB goes out first)
   localparam int ST_MSB    = 31;
   localparam int ST_LSB    = 30;
   localparam int OP_MSB    = 29;
   localparam int OP_LSB    = 28;
   localparam int PHYAD_MSB = 27;
   localparam int PHYAD_LSB = 23;
   localparam int REGAD_MSB = 22;
   localparam int REGAD_LSB = 18;
   localparam int TA_MSB    = 17;
   localparam int TA_LSB    = 16;
   localparam int WDATA_MSB = 15;
   localparam int WDATA_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_RECEIVE = 2'd2
   } mdio_state_e;

   // Debug view of the controller, for checkers and waveform reading
   typedef struct packed {
      mdio_state_e            state;
      logic [BIT_IDX_W-1:0]   bit_idx;
      logic                   mdc_rise;
      logic                   mdc_fall;
   } mdio_dbg_t;

   // Only the read opcode turns the bus around; every other code is a write
   function automatic logic is_read_op(input logic [1:0] op);
      return op == OP_READ;
   endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator. While active, MDC runs low for MDC_HALF cycles then high for
// MDC_HALF cycles. rise_o / fall_o are high in the cycle whose closing edge
// raises / lowers MDC. When inactive MDC is held low and the phase restarts.
module mdio_clkgen #(
   parameter int MDC_HALF = 1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic active_i,
   output logic mdc_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int              CW   = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
   localparam logic [CW-1:0]   LAST = CW'(MDC_HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          mdc_q, mdc_d;
   logic          phase_end;

   assign phase_end = active_i && (cnt_q == LAST);
   assign rise_o    = phase_end && !mdc_q;
   assign fall_o    = phase_end && mdc_q;
   assign mdc_o     = mdc_q;

   // Next phase counter / MDC level
   always_comb begin
      cnt_d = cnt_q;
      mdc_d = mdc_q;
      if (!active_i) begin
         cnt_d = '0;
         mdc_d = 1'b0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
         mdc_d = ~mdc_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Phase counter and MDC registers
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         mdc_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         mdc_q <= mdc_d;
      end
   end

endmodule

// File: rtl/mdio_controller.sv
// Clause-22 style MDIO master. Shifts a 32-bit frame out on MDIO, turning the
// bus around after REGAD for reads and capturing 16 data bits from the PHY.
//
// Request handshake: MDIO_START is a level sampled only while idle. The edge
// that sees MDIO_START=1 in IDLE accepts the request and latches T_DATA; the
// caller may change T_DATA afterwards. There is no ready output: MDIO_START
// outside IDLE is simply ignored, so callers wait for the frame to end (or
// for DATA_RDY on reads) before requesting again.
module mdio_controller
   import mdio_pkg::*;
#(
   parameter int MDC_HALF = 1
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 MDIO_START,
   input  logic [31:0]          T_DATA,
   input  logic                 MDIO_IN,
   output logic [15:0]          RD_DATA,
   output logic                 DATA_RDY,
   output logic                 MDC,
   output logic                 MDIO_OE,
   output logic                 MDIO_OUT,
   output mdio_dbg_t            DBG_O
);

   localparam logic [BIT_IDX_W-1:0] LAST_SEND_WR = BIT_IDX_W'(FRAME_BITS - 1);
   localparam logic [BIT_IDX_W-1:0] LAST_SEND_RD = BIT_IDX_W'(READ_DRIVE_BITS - 1);
   localparam logic [BIT_IDX_W-1:0] FIRST_DATA   = BIT_IDX_W'(TA_BITS);
   localparam logic [BIT_IDX_W-1:0] LAST_RX      = BIT_IDX_W'(TA_BITS + DATA_BITS - 1);

   mdio_state_e                state_q;
   logic [FRAME_BITS-2:0]      shift_q;
   logic [BIT_IDX_W-1:0]       bit_idx_q;
   logic [DATA_BITS-2:0]       rx_q;
   logic [DATA_BITS-1:0]       rd_data_q;
   logic                       data_rdy_q;
   logic                       oe_q;
   logic                       out_q;
   logic                       is_read_q;

   logic                       mdc;
   logic                       mdc_rise;
   logic                       mdc_fall;

   mdio_clkgen #(
      .MDC_HALF (MDC_HALF)
   ) u_clkgen (
      .clk_i    (CLK),
      .rst_n_i  (RESET),
      .active_i (state_q != ST_IDLE),
      .mdc_o    (mdc),
      .rise_o   (mdc_rise),
      .fall_o   (mdc_fall)
   );

   // Frame sequencer: every step happens on the edge that ends a high phase,
   // which is also the start of the next low phase, so MDIO_OUT only moves
   // while MDC is low.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         rx_q       <= '0;
         rd_data_q  <= '0;
         data_rdy_q <= 1'b0;
         oe_q       <= 1'b0;
         out_q      <= 1'b0;
         is_read_q  <= 1'b0;
      end else begin
         data_rdy_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               oe_q  <= 1'b0;
               out_q <= 1'b0;
               if (MDIO_START) begin
                  // Bit 31 goes straight to the pin; the rest waits in shift_q
                  out_q     <= T_DATA[FRAME_BITS-1];
                  shift_q   <= T_DATA[FRAME_BITS-2:0];
                  oe_q      <= 1'b1;
                  bit_idx_q <= '0;
                  is_read_q <= is_read_op(T_DATA[OP_MSB:OP_LSB]);
                  state_q   <= ST_SEND;
               end
            end

            ST_SEND: begin
               if (mdc_fall) begin
                  if (is_read_q && (bit_idx_q == LAST_SEND_RD)) begin
                     // Release the bus for turnaround and PHY data
                     oe_q      <= 1'b0;
                     out_q     <= 1'b0;
                     bit_idx_q <= '0;
                     state_q   <= ST_RECEIVE;
                  end else if (!is_read_q && (bit_idx_q == LAST_SEND_WR)) begin
                     oe_q      <= 1'b0;
                     out_q     <= 1'b0;
                     bit_idx_q <= '0;
                     state_q   <= ST_IDLE;
                  end else begin
                     out_q     <= shift_q[FRAME_BITS-2];
                     shift_q   <= {shift_q[FRAME_BITS-3:0], 1'b0};
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end
            end

            ST_RECEIVE: begin
               if (mdc_fall) begin
                  // The two turnaround samples are dropped
                  if (bit_idx_q >= FIRST_DATA) begin
                     rx_q <= {rx_q[DATA_BITS-3:0], MDIO_IN};
                  end
                  if (bit_idx_q == LAST_RX) begin
                     rd_data_q  <= {rx_q, MDIO_IN};
                     data_rdy_q <= 1'b1;
                     bit_idx_q  <= '0;
                     state_q    <= ST_IDLE;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end
            end

            default: begin
               oe_q    <= 1'b0;
               out_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign RD_DATA  = rd_data_q;
   assign DATA_RDY = data_rdy_q;
   assign MDC      = mdc;
   assign MDIO_OE  = oe_q;
   assign MDIO_OUT = out_q;

   // Debug view of the sequencer
   always_comb begin
      DBG_O          = '0;
      DBG_O.state    = state_q;
      DBG_O.bit_idx  = bit_idx_q;
      DBG_O.mdc_rise = mdc_rise;
      DBG_O.mdc_fall = mdc_fall;
   end

endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller: directed and random frames on a default
// instance (MDC_HALF=1) and a slow instance (MDC_HALF=3), compared cycle by
// cycle against timing and data computed from the frame rules.
module tb_mdio_controller;
   import mdio_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        sel3;
   logic [31:0] t_data;
   logic        mdio_in;
   logic        start1, start3;

   logic [15:0] rd1, rd3, rd_s;
   logic        rdy1, rdy3, rdy_s;
   logic        mdc1, mdc3, mdc_s;
   logic        oe1, oe3, oe_s;
   logic        out1, out3, out_s;
   mdio_dbg_t   dbg1, dbg3;

   int          tests_run = 0;
   int          fail_cnt  = 0;
   logic [15:0] exp_rd1   = '0;
   logic [15:0] exp_rd3   = '0;

   // Clock
   always #5 clk = ~clk;

   assign start1 = start & ~sel3;
   assign start3 = start & sel3;
   assign rd_s   = sel3 ? rd3  : rd1;
   assign rdy_s  = sel3 ? rdy3 : rdy1;
   assign mdc_s  = sel3 ? mdc3 : mdc1;
   assign oe_s   = sel3 ? oe3  : oe1;
   assign out_s  = sel3 ? out3 : out1;

   mdio_controller #(.MDC_HALF(1)) dut (
      .CLK        (clk),
      .RESET      (reset_n),
      .MDIO_START (start1),
      .T_DATA     (t_data),
      .MDIO_IN    (mdio_in),
      .RD_DATA    (rd1),
      .DATA_RDY   (rdy1),
      .MDC        (mdc1),
      .MDIO_OE    (oe1),
      .MDIO_OUT   (out1),
      .DBG_O      (dbg1)
   );

   mdio_controller #(.MDC_HALF(3)) dut3 (
      .CLK        (clk),
      .RESET      (reset_n),
      .MDIO_START (start3),
      .T_DATA     (t_data),
      .MDIO_IN    (mdio_in),
      .RD_DATA    (rd3),
      .DATA_RDY   (rdy3),
      .MDC        (mdc3),
      .MDIO_OE    (oe3),
      .MDIO_OUT   (out3),
      .DBG_O      (dbg3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         fail_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Advance one clock and park on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One frame on the selected instance. Presents START with td on the
   // current falling edge; the next rising edge is the latch edge (cycle 0).
   // abort_at>0 pulls reset during that cycle; ign_td!=0 pulses a stray START
   // mid-frame; chain leaves the bench parked in the first idle cycle.
   task automatic run_frame(input int h, input logic [31:0] td, input logic [15:0] rw,
                            input int abort_at, input logic [31:0] ign_td, input bit chain);
      bit          is_rd   = (td[29:28] == 2'b10);
      int          per     = 2 * h;
      int          total   = 32 * per;
      int          drv     = (is_rd ? 14 : 32) * per;
      logic [31:0] got     = '0;
      logic [15:0] prev_rd = sel3 ? exp_rd3 : exp_rd1;
      int          ph, b, j;
      t_data = td;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      t_data = $urandom;
      for (int c = 1; c <= total; c++) begin
         ph = (c - 1) % per;
         b  = (c - 1) / per;
         if (c == abort_at) begin
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            check("abort_ctl", {28'd0, mdc_s, oe_s, out_s, rdy_s}, 32'd0);
            check("abort_rd", {16'd0, rd_s}, 32'd0);
            check("abort_state", {30'd0, dbg1.state}, {30'd0, ST_IDLE});
            exp_rd1 = '0;
            exp_rd3 = '0;
            for (int k = 0; k < 4; k++) begin
               tick();
               check("abort_idle", {29'd0, mdc_s, oe_s, rdy_s}, 32'd0);
            end
            return;
         end
         // PHY side: a new bit at the start of each receive bit period
         if (ph == 0) begin
            if (is_rd && c > drv) begin
               j = b - 14;
               mdio_in = (j == 0) ? 1'b1 : (j == 1) ? 1'b0 : rw[17 - j];
            end else begin
               mdio_in = 1'($urandom);
            end
         end
         if (ign_td != 0 && c == 20) begin
            t_data = ign_td;
            start  = 1'b1;
         end
         if (c == 21) start = 1'b0;
         check("frame_ctl", {29'd0, mdc_s, oe_s, rdy_s},
               {29'd0, 1'(ph >= h), 1'(c <= drv), 1'b0});
         check("rd_hold", {16'd0, rd_s}, {16'd0, prev_rd});
         if (c > drv) check("out_released", {31'd0, out_s}, 32'd0);
         if (ph == h && c <= drv) got = {got[30:0], out_s};
         tick();
      end
      // First cycle after the final edge
      if (is_rd) begin
         check("rd_addr_bits", {18'd0, got[13:0]}, {18'd0, td[31:18]});
         check("rd_data", {16'd0, rd_s}, {16'd0, rw});
         if (sel3) exp_rd3 = rw;
         else      exp_rd1 = rw;
      end else begin
         check("wr_bits", got, td);
      end
      check("end_ctl", {29'd0, mdc_s, oe_s, rdy_s}, {31'd0, is_rd});
      if (!chain) begin
         for (int k = 0; k < 2 * per; k++) begin
            tick();
            check("idle_ctl", {29'd0, mdc_s, oe_s, rdy_s}, 32'd0);
            check("idle_rd", {16'd0, rd_s}, {16'd0, sel3 ? exp_rd3 : exp_rd1});
         end
      end
   endtask

   initial begin
      logic [31:0] td;
      logic [15:0] rw;
      bit          ch;

      // Reset held with START asserted
      reset_n = 1'b0;
      start   = 1'b1;
      sel3    = 1'b0;
      t_data  = 32'h5088ABCD;
      mdio_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("reset_ctl", {28'd0, mdc1, oe1, out1, rdy1}, 32'd0);
         check("reset_rd", {16'd0, rd1}, 32'd0);
         check("reset_ctl3", {12'd0, rd3, mdc3, oe3, out3, rdy3}, 32'd0);
      end
      check("reset_state", {30'd0, dbg1.state}, {30'd0, ST_IDLE});
      check("reset_state3", {30'd0, dbg3.state}, {30'd0, ST_IDLE});
      reset_n = 1'b1;
      start   = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("post_reset_idle", {28'd0, mdc1, oe1, out1, rdy1}, 32'd0);
      end

      // Read aborted by reset during receive bit 10, before any good read
      run_frame(1, 32'h61900000, 16'hA5C3, 24 * 2 + 2, 32'd0, 1'b0);
      // Read after the abort completes normally
      run_frame(1, 32'h61900000, 16'h1234, 0, 32'd0, 1'b0);
      // Write with a stray START and different T_DATA mid-frame
      run_frame(1, 32'h5088ABCD, 16'h0000, 0, 32'h6FFF0000, 1'b0);
      // Back-to-back: read then write accepted in the first idle cycle
      run_frame(1, 32'h69A40000, 16'hBEEF, 0, 32'd0, 1'b1);
      run_frame(1, 32'h5C2E0F0F, 16'h0000, 0, 32'd0, 1'b0);

      // Random frames, random opcode, occasionally chained
      for (int n = 0; n < 10; n++) begin
         td = $urandom;
         td[29:28] = 2'($urandom_range(0, 3));
         rw = 16'($urandom);
         ch = (n != 9) && ($urandom_range(0, 1) == 1);
         run_frame(1, td, rw, 0, 32'd0, ch);
      end

      // Slow MDC instance
      sel3 = 1'b1;
      run_frame(3, 32'h61900000, 16'hFFFF, 0, 32'd0, 1'b0);
      td = $urandom;
      td[29:28] = 2'b01;
      run_frame(3, td, 16'h0000, 0, 32'd0, 1'b0);
      td[29:28] = 2'b10;
      run_frame(3, td, 16'($urandom), 0, 32'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
